// File: rtl/serial_add_sub_if.sv
// Start/busy/done handshake and operand/result bundle for the serial add/subtract unit.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock,
// carry rippled through a register between chunks.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input logic             clk,
  input logic             rst,
  serial_add_sub_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             ripple, c_out, c_msb;
  logic             last;

  assign last = (k_q == KW'(NCHUNK - 1));

  // Bit-level ripple over the current chunk; c_msb is the carry into the chunk's top bit.
  always_comb begin
    a_chunk = a_q[int'(k_q) * CHUNK +: CHUNK];
    b_chunk = b_q[int'(k_q) * CHUNK +: CHUNK];
    s_chunk = '0;
    c_msb   = 1'b0;
    ripple  = c_q;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (i == int'(CHUNK) - 1) c_msb = ripple;
      s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ ripple;
      ripple     = (a_chunk[i] & b_chunk[i]) | (ripple & (a_chunk[i] ^ b_chunk[i]));
    end
    c_out = ripple;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    k_d     = k_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        part_d[int'(k_q) * CHUNK +: CHUNK] = s_chunk;
        c_d = c_out;
        k_d = k_q + KW'(1);
        if (last) begin
          state_d = DONE;
          k_d     = '0;
          sum_d   = part_d;
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
        end
      end
      default: state_d = IDLE;
    endcase

    // Subtraction is a + ~b + ~cin, so invert at the latch and reuse the adder.
    if (state_q != RUN && bus.start) begin
      state_d = RUN;
      a_d     = bus.a;
      b_d     = bus.mode ? ~bus.b : bus.b;
      c_d     = bus.mode ? ~bus.cin : bus.cin;
      k_d     = '0;
      part_d  = '0;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      part_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      k_q     <= k_d;
      part_q  <= part_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: CHUNK=2 and CHUNK=8 instances side by side,
// hand-computed results, handshake and reset-in-flight cases.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(8)) bus2 ();
  serial_add_sub_if #(.WIDTH(8)) bus8 ();

  serial_add_sub #(.WIDTH(8), .CHUNK(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  serial_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [9:0]  prev_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] res2();
    return {bus2.cout, bus2.ovf, bus2.sum};
  endfunction

  function automatic logic [9:0] res8();
    return {bus8.cout, bus8.ovf, bus8.sum};
  endfunction

  task automatic drive2(input logic st, input logic m, input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
    bus2.start = st; bus2.mode = m; bus2.a = a; bus2.b = b; bus2.cin = ci;
  endtask

  task automatic drive8(input logic st, input logic m, input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
    bus8.start = st; bus8.mode = m; bus8.a = a; bus8.b = b; bus8.cin = ci;
  endtask

  // One operation on both instances; exp is {cout, ovf, sum}.
  task automatic op(input string name, input logic m, input logic [7:0] a, input logic [7:0] b,
                    input logic ci, input logic [9:0] exp);
    @(negedge clk);
    drive2(1'b1, m, a, b, ci);
    drive8(1'b1, m, a, b, ci);
    @(posedge clk);
    #1;
    drive2(1'b0, ~m, ~a, ~b, ~ci);
    drive8(1'b0, ~m, ~a, ~b, ~ci);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("%s c2 busy cyc%0d", name, i), 32'(bus2.busy), 32'(i <= 4));
      chk($sformatf("%s c2 done cyc%0d", name, i), 32'(bus2.done), 32'(i == 5));
      if (i <= 2) begin
        chk($sformatf("%s c8 busy cyc%0d", name, i), 32'(bus8.busy), 32'(i == 1));
        chk($sformatf("%s c8 done cyc%0d", name, i), 32'(bus8.done), 32'(i == 2));
      end
      if (i == 1) chk($sformatf("%s c8 hold", name), 32'(res8()), 32'(prev_res));
      if (i == 2) chk($sformatf("%s c8 res", name), 32'(res8()), 32'(exp));
      if (i == 4) chk($sformatf("%s c2 hold", name), 32'(res2()), 32'(prev_res));
      if (i == 5) chk($sformatf("%s c2 res", name), 32'(res2()), 32'(exp));
    end
    prev_res = exp;
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1;
    drive2(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    prev_res = 10'h000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst c2 busy/done %0d", i), 32'({bus2.busy, bus2.done}), 32'h0);
      chk($sformatf("rst c8 busy/done %0d", i), 32'({bus8.busy, bus8.done}), 32'h0);
    end
    chk("rst c2 res", 32'(res2()), 32'h0);
    chk("rst c8 res", 32'(res8()), 32'h0);

    op("add5a3c", 1'b0, 8'h5A, 8'h3C, 1'b0, {1'b0, 1'b1, 8'h96});
    op("addff01", 1'b0, 8'hFF, 8'h01, 1'b1, {1'b1, 1'b0, 8'h01});
    op("sub1020", 1'b1, 8'h10, 8'h20, 1'b0, {1'b0, 1'b0, 8'hF0});
    op("sub8001", 1'b1, 8'h80, 8'h01, 1'b0, {1'b1, 1'b1, 8'h7F});
    op("sub5020", 1'b1, 8'h50, 8'h20, 1'b1, {1'b1, 1'b0, 8'h2F});

    // Start during RUN must be ignored.
    @(negedge clk);
    drive2(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0);
    @(posedge clk);
    #1 drive2(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) drive2(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
      else        bus2.start = 1'b0;
      chk($sformatf("ign busy cyc%0d", i), 32'(bus2.busy), 32'(i <= 4));
      chk($sformatf("ign done cyc%0d", i), 32'(bus2.done), 32'(i == 5));
      if (i == 5) chk("ign res", 32'(res2()), 32'({1'b0, 1'b1, 8'h80}));
    end

    // Start held in the DONE cycle launches the next operation back-to-back.
    @(negedge clk);
    drive2(1'b1, 1'b0, 8'h01, 8'h02, 1'b0);
    @(posedge clk);
    #1 bus2.start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) drive2(1'b1, 1'b1, 8'h00, 8'h01, 1'b0);
      else        bus2.start = 1'b0;
      chk($sformatf("b2b busy cyc%0d", i), 32'(bus2.busy), 32'((i <= 4) || (i >= 6 && i <= 9)));
      chk($sformatf("b2b done cyc%0d", i), 32'(bus2.done), 32'(i == 5 || i == 10));
      if (i == 5)  chk("b2b res1", 32'(res2()), 32'({1'b0, 1'b0, 8'h03}));
      if (i == 7)  chk("b2b hold", 32'(res2()), 32'({1'b0, 1'b0, 8'h03}));
      if (i == 10) chk("b2b res2", 32'(res2()), 32'({1'b0, 1'b0, 8'hFF}));
    end

    // Reset in the third RUN cycle abandons the operation.
    @(negedge clk);
    drive2(1'b1, 1'b0, 8'h5A, 8'h3C, 1'b0);
    @(posedge clk);
    #1 bus2.start = 1'b0;
    seen_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b1;
      if (i == 4) begin
        rst = 1'b0;
        chk("rrun busy/done", 32'({bus2.busy, bus2.done}), 32'h0);
        chk("rrun res", 32'(res2()), 32'h0);
      end
      if (i >= 4 && bus2.done) seen_done = 1'b1;
    end
    chk("rrun no done", 32'(seen_done), 32'h0);
    prev_res = 10'h000;

    op("addff01b", 1'b0, 8'hFF, 8'h01, 1'b1, {1'b1, 1'b0, 8'h01});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
